branch_predictor: RTL and testbench

Parametrised dynamic branch predictor for the 5-stage pipelined RV32I core. It sits beside the IF-stage PC mux and supplies a predicted next PC every cycle. It is trained by branch/jump resolution from the EX stage. It replaces the fixed "predict not-taken, flush on EX/MEM bcond" scheme with selectable modes: always-not-taken, bimodal and gshare. A saturating misprediction counter is kept for performance runs.

---
 rtl/bp_pkg.sv | 23 ++
 rtl/branch_predictor_if.sv | 25 ++
 rtl/branch_target_buffer.sv | 60 ++++++
 rtl/branch_predictor.sv | 131 +++++++++++++
 tb/tb_branch_predictor.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/bp_pkg.sv
// Shared constants, types and helpers for the dynamic branch predictor.
package bp_pkg;

  localparam int BP_MODE_NT      = 0;
  localparam int BP_MODE_BIMODAL = 1;
  localparam int BP_MODE_GSHARE  = 2;

  // Widest PC the BTB storage type can hold; narrower PCs are zero-extended.
  localparam int BP_MAX_ADDR_W = 32;

  typedef struct packed {
    logic                     valid;
    logic                     is_jump;
    logic [BP_MAX_ADDR_W-1:0] tag;
    logic [BP_MAX_ADDR_W-1:0] target;
  } btb_entry_t;

  // Weakly-not-taken value of a CTR_BITS-wide saturating counter.
  function automatic int bp_ctr_reset(input int ctr_bits);
    return (32'sd1 <<< (ctr_bits - 32'sd1)) - 32'sd1;
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-side lookup and EX-side training bundle between the core and the predictor.
interface branch_predictor_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] if_pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_next_pc;
  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_is_cond;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_mispredict;
  logic [31:0]       mispredict_cnt;

  modport master (
    output if_pc, upd_valid, upd_pc, upd_is_cond, upd_taken, upd_target, upd_mispredict,
    input  pred_taken, pred_next_pc, mispredict_cnt
  );

  modport slave (
    input  if_pc, upd_valid, upd_pc, upd_is_cond, upd_taken, upd_target, upd_mispredict,
    output pred_taken, pred_next_pc, mispredict_cnt
  );
endinterface

// File: rtl/branch_target_buffer.sv
// Direct-mapped BTB: combinational read port, one registered write port,
// asynchronous clear on reset.
module branch_target_buffer
  import bp_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int ENTRIES = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rd_pc_i,
  output logic              rd_hit_o,
  output logic              rd_is_jump_o,
  output logic [ADDR_W-1:0] rd_target_o,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_pc_i,
  input  logic [ADDR_W-1:0] wr_target_i,
  input  logic              wr_is_jump_i
);
  localparam int IDX_W = $clog2(ENTRIES);

  btb_entry_t               entry_q [ENTRIES];
  btb_entry_t               rd_entry_s;
  btb_entry_t               wr_entry_s;
  logic [IDX_W-1:0]         rd_idx_s;
  logic [IDX_W-1:0]         wr_idx_s;
  logic [BP_MAX_ADDR_W-1:0] rd_tag_s;
  logic                     unused_s;

  // PCs are word aligned, so the two low bits never select anything.
  assign unused_s = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

  assign rd_idx_s     = rd_pc_i[IDX_W+1:2];
  assign rd_tag_s     = BP_MAX_ADDR_W'(rd_pc_i[ADDR_W-1:IDX_W+2]);
  assign rd_entry_s   = entry_q[rd_idx_s];
  assign rd_hit_o     = rd_entry_s.valid && (rd_entry_s.tag == rd_tag_s);
  assign rd_is_jump_o = rd_entry_s.is_jump;
  assign rd_target_o  = rd_entry_s.target[ADDR_W-1:0];

  assign wr_idx_s = wr_pc_i[IDX_W+1:2];

  always_comb begin
    wr_entry_s         = '0;
    wr_entry_s.valid   = 1'b1;
    wr_entry_s.is_jump = wr_is_jump_i;
    wr_entry_s.tag     = BP_MAX_ADDR_W'(wr_pc_i[ADDR_W-1:IDX_W+2]);
    wr_entry_s.target  = BP_MAX_ADDR_W'(wr_target_i);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entry_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      entry_q[wr_idx_s] <= wr_entry_s;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor (not-taken / bimodal / gshare) beside the IF-stage PC mux,
// trained from EX-stage resolution, with a saturating mispredict counter.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int BTB_ENTRIES = 32,
  parameter int PHT_IDX_W   = 5,
  parameter int GHR_BITS    = 5,
  parameter int CTR_BITS    = 2,
  parameter int MODE        = BP_MODE_GSHARE
) (
  input logic                clk,
  input logic                reset,
  branch_predictor_if.slave  bus
);
  localparam int PHT_N = 1 << PHT_IDX_W;
  localparam logic [CTR_BITS-1:0] CTR_RST  = CTR_BITS'(bp_ctr_reset(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_MAX  = {CTR_BITS{1'b1}};
  localparam logic [CTR_BITS-1:0] CTR_ZERO = {CTR_BITS{1'b0}};
  localparam bit TRAIN  = (MODE != BP_MODE_NT);
  localparam bit GSHARE = (MODE == BP_MODE_GSHARE);

  logic [CTR_BITS-1:0]  pht_q [PHT_N];
  logic [CTR_BITS-1:0]  ctr_d;
  logic [CTR_BITS-1:0]  upd_ctr_s;
  logic [CTR_BITS-1:0]  lk_ctr_s;
  logic [GHR_BITS-1:0]  ghr_q;
  logic [GHR_BITS-1:0]  ghr_d;
  logic [31:0]          mispredict_cnt_q;
  logic [31:0]          mispredict_cnt_d;
  logic [PHT_IDX_W-1:0] ghr_ext_s;
  logic [PHT_IDX_W-1:0] lk_idx_s;
  logic [PHT_IDX_W-1:0] upd_idx_s;
  logic                 btb_hit_s;
  logic                 btb_is_jump_s;
  logic [ADDR_W-1:0]    btb_target_s;
  logic                 btb_we_s;
  logic                 pht_we_s;
  logic                 pred_s;

  function automatic logic [PHT_IDX_W-1:0] pht_index(input logic [ADDR_W-1:0] pc,
                                                     input logic [PHT_IDX_W-1:0] hist);
    return pc[PHT_IDX_W+1:2] ^ (GSHARE ? hist : {PHT_IDX_W{1'b0}});
  endfunction

  assign ghr_ext_s = PHT_IDX_W'(ghr_q);
  assign lk_idx_s  = pht_index(bus.if_pc, ghr_ext_s);
  assign upd_idx_s = pht_index(bus.upd_pc, ghr_ext_s);
  assign lk_ctr_s  = pht_q[lk_idx_s];
  assign upd_ctr_s = pht_q[upd_idx_s];

  // Not-taken conditionals never allocate; jumps and taken branches always (re)write.
  assign btb_we_s = TRAIN && bus.upd_valid && (!bus.upd_is_cond || bus.upd_taken);
  assign pht_we_s = TRAIN && bus.upd_valid && bus.upd_is_cond;

  branch_target_buffer #(
    .ADDR_W  (ADDR_W),
    .ENTRIES (BTB_ENTRIES)
  ) u_btb (
    .clk          (clk),
    .reset        (reset),
    .rd_pc_i      (bus.if_pc),
    .rd_hit_o     (btb_hit_s),
    .rd_is_jump_o (btb_is_jump_s),
    .rd_target_o  (btb_target_s),
    .wr_en_i      (btb_we_s),
    .wr_pc_i      (bus.upd_pc),
    .wr_target_i  (bus.upd_target),
    .wr_is_jump_i (!bus.upd_is_cond)
  );

  always_comb begin
    pred_s = 1'b0;
    if (reset || !TRAIN || !btb_hit_s) begin
      pred_s = 1'b0;
    end else if (btb_is_jump_s) begin
      pred_s = 1'b1;
    end else begin
      pred_s = lk_ctr_s[CTR_BITS-1];
    end
  end

  assign bus.pred_taken     = pred_s;
  assign bus.pred_next_pc   = pred_s ? btb_target_s : bus.if_pc + ADDR_W'(4);
  assign bus.mispredict_cnt = mispredict_cnt_q;

  always_comb begin
    ctr_d = upd_ctr_s;
    if (bus.upd_taken) begin
      if (upd_ctr_s != CTR_MAX) ctr_d = upd_ctr_s + CTR_BITS'(1);
      else                      ctr_d = upd_ctr_s;
    end else begin
      if (upd_ctr_s != CTR_ZERO) ctr_d = upd_ctr_s - CTR_BITS'(1);
      else                       ctr_d = upd_ctr_s;
    end
  end

  // Truncating the concatenation shifts the newest outcome into bit 0 for any GHR_BITS.
  assign ghr_d = GHR_BITS'({ghr_q, bus.upd_taken});

  assign mispredict_cnt_d = (bus.upd_valid && bus.upd_mispredict && (mispredict_cnt_q != 32'hFFFF_FFFF))
                          ? mispredict_cnt_q + 32'd1 : mispredict_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PHT_N; i++) begin
        pht_q[i] <= CTR_RST;
      end
    end else if (pht_we_s) begin
      pht_q[upd_idx_s] <= ctr_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_q <= {GHR_BITS{1'b0}};
    end else if (pht_we_s) begin
      ghr_q <= ghr_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mispredict_cnt_q <= 32'd0;
    end else begin
      mispredict_cnt_q <= mispredict_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Drives one stimulus stream into gshare, bimodal and not-taken predictors and
// checks each against hand-derived expectations through a scoreboard queue.
module tb_branch_predictor;
  import bp_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_pc, upd_pc, upd_target;
  logic        upd_valid, upd_is_cond, upd_taken, upd_mispredict;

  logic [2:0]  pt_s;
  logic [31:0] npc_s [3];
  logic [31:0] cnt_s [3];

  always #5 clk = ~clk;

  // Instance 0 = gshare, 1 = bimodal, 2 = always-not-taken.
  genvar k;
  generate
    for (k = 0; k < 3; k++) begin : g_dut
      branch_predictor_if #(.ADDR_W(32)) bus ();
      assign bus.if_pc          = if_pc;
      assign bus.upd_valid      = upd_valid;
      assign bus.upd_pc         = upd_pc;
      assign bus.upd_is_cond    = upd_is_cond;
      assign bus.upd_taken      = upd_taken;
      assign bus.upd_target     = upd_target;
      assign bus.upd_mispredict = upd_mispredict;
      assign pt_s[k]  = bus.pred_taken;
      assign npc_s[k] = bus.pred_next_pc;
      assign cnt_s[k] = bus.mispredict_cnt;
      branch_predictor #(
        .MODE ((k == 0) ? BP_MODE_GSHARE : ((k == 1) ? BP_MODE_BIMODAL : BP_MODE_NT))
      ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
      );
    end
  endgenerate

  typedef struct {
    string       name;
    int          d;
    logic        taken;
    logic [31:0] npc;
    bit          chk_cnt;
    logic [31:0] cnt;
  } exp_t;

  typedef struct {
    bit          is_upd;
    logic [31:0] pc;
    logic        is_cond;
    logic        taken;
    logic [31:0] target;
    logic        mis;
    logic [2:0]  ept;
    logic [31:0] npc_g, npc_b, npc_n;
    logic [31:0] cnt;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s dut%0d: got %h expected %h", name, d, act, exp);
    else n_pass++;
  endtask

  task automatic drain();
    exp_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.name, "_taken"}, e.d, 32'(pt_s[e.d]), 32'(e.taken));
      chk({e.name, "_npc"}, e.d, npc_s[e.d], e.npc);
      if (e.chk_cnt) chk({e.name, "_cnt"}, e.d, cnt_s[e.d], e.cnt);
    end
  endtask

  task automatic push3(input string name, input logic [2:0] ept, input logic [31:0] ng,
                       input logic [31:0] nb, input logic [31:0] nn, input bit cc, input logic [31:0] c);
    sb.push_back('{name, 0, ept[0], ng, cc, c});
    sb.push_back('{name, 1, ept[1], nb, cc, c});
    sb.push_back('{name, 2, ept[2], nn, cc, c});
  endtask

  task automatic look(input string name, input logic [31:0] pc, input logic [2:0] ept, input logic [31:0] ng,
                      input logic [31:0] nb, input logic [31:0] nn, input bit cc, input logic [31:0] c);
    if_pc = pc;
    push3(name, ept, ng, nb, nn, cc, c);
    @(negedge clk);
    drain();
    @(posedge clk);
    #1;
  endtask

  task automatic upd(input logic [31:0] pc, input logic cond, input logic tk, input logic [31:0] tgt, input logic mis);
    upd_pc = pc; upd_is_cond = cond; upd_taken = tk; upd_target = tgt; upd_mispredict = mis;
    upd_valid = 1'b1;
    @(posedge clk);
    #1;
    upd_valid = 1'b0; upd_mispredict = 1'b0;
  endtask

  function automatic vec_t lk(input logic [31:0] pc, input logic [2:0] ept, input logic [31:0] ng,
                              input logic [31:0] nb, input logic [31:0] nn, input logic [31:0] c);
    return '{1'b0, pc, 1'b0, 1'b0, 32'h0, 1'b0, ept, ng, nb, nn, c};
  endfunction

  function automatic vec_t up(input logic [31:0] pc, input logic cond, input logic tk,
                              input logic [31:0] tgt, input logic mis);
    return '{1'b1, pc, cond, tk, tgt, mis, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0};
  endfunction

  initial begin
    logic act, gp;
    reset = 1'b0; if_pc = 32'h40; upd_valid = 1'b0; upd_pc = 32'h0; upd_is_cond = 1'b0;
    upd_taken = 1'b0; upd_target = 32'h0; upd_mispredict = 1'b0;
    #1 reset = 1'b1;
    look("in_reset", 32'h40, 3'b000, 32'h44, 32'h44, 32'h44, 1'b1, 32'd0);
    reset = 1'b0;

    // Training expectations: bimodal follows pht[0]; gshare indexes with the evolving GHR.
    vecs.push_back(lk(32'h40, 3'b000, 32'h44, 32'h44, 32'h44, 32'd0));
    vecs.push_back(up(32'h40, 1'b0, 1'b0, 32'h100, 1'b1));
    vecs.push_back(lk(32'h40, 3'b011, 32'h100, 32'h100, 32'h44, 32'd1));
    vecs.push_back(lk(32'hFFFF_FFFC, 3'b000, 32'h0, 32'h0, 32'h0, 32'd1));
    vecs.push_back(up(32'h80, 1'b1, 1'b1, 32'h300, 1'b1));
    vecs.push_back(lk(32'h80, 3'b010, 32'h84, 32'h300, 32'h84, 32'd2));
    vecs.push_back(up(32'h80, 1'b1, 1'b1, 32'h300, 1'b0));
    vecs.push_back(up(32'h80, 1'b1, 1'b0, 32'h300, 1'b1));
    vecs.push_back(lk(32'h80, 3'b010, 32'h84, 32'h300, 32'h84, 32'd3));
    vecs.push_back(up(32'h1080, 1'b0, 1'b0, 32'h500, 1'b0));
    vecs.push_back(lk(32'h80, 3'b000, 32'h84, 32'h84, 32'h84, 32'd3));
    vecs.push_back(lk(32'h1080, 3'b011, 32'h500, 32'h500, 32'h1084, 32'd3));
    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].is_upd)
        upd(vecs[i].pc, vecs[i].is_cond, vecs[i].taken, vecs[i].target, vecs[i].mis);
      else
        look($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ept, vecs[i].npc_g, vecs[i].npc_b,
             vecs[i].npc_n, 1'b1, vecs[i].cnt);
    end
    chk("gshare_ghr", 0, 32'(g_dut[0].dut.ghr_q), 32'h06);
    chk("bimodal_ctr", 1, 32'(g_dut[1].dut.pht_q[0]), 32'd2);

    // Same-cycle lookup and update: old state now, new state next cycle.
    if_pc = 32'h140;
    upd_pc = 32'h140; upd_is_cond = 1'b0; upd_taken = 1'b0; upd_target = 32'h600; upd_valid = 1'b1;
    push3("same_cyc_old", 3'b000, 32'h144, 32'h144, 32'h144, 1'b0, 32'd0);
    @(negedge clk);
    drain();
    @(posedge clk);
    #1 upd_valid = 1'b0;
    look("same_cyc_new", 32'h140, 3'b011, 32'h600, 32'h600, 32'h144, 1'b0, 32'd0);

    // Asynchronous reset in the middle of a cycle.
    look("pre_reset", 32'h1080, 3'b011, 32'h500, 32'h500, 32'h1084, 1'b1, 32'd3);
    reset = 1'b1;
    #2;
    push3("async_reset", 3'b000, 32'h1084, 32'h1084, 32'h1084, 1'b1, 32'd0);
    drain();
    @(posedge clk);
    #1 reset = 1'b0;

    // Loop T,T,T,N x8 at 0x200: gshare must be perfect on the last pass, NT never taken.
    for (int it = 0; it < 8; it++) begin
      for (int p = 0; p < 4; p++) begin
        act = (p != 3);
        if_pc = 32'h200;
        if (it == 7) sb.push_back('{"gshare_loop", 0, act, act ? 32'h800 : 32'h204, 1'b0, 32'd0});
        sb.push_back('{"nt_never", 2, 1'b0, 32'h204, 1'b0, 32'd0});
        @(negedge clk);
        gp = pt_s[0];
        drain();
        upd_pc = 32'h200; upd_is_cond = 1'b1; upd_taken = act; upd_target = 32'h800;
        upd_mispredict = (gp != act); upd_valid = 1'b1;
        @(posedge clk);
        #1 upd_valid = 1'b0; upd_mispredict = 1'b0;
      end
    end
    chk("loop_ghr", 0, 32'(g_dut[0].dut.ghr_q), 32'h0E);
    chk("bimodal_sat_hi", 1, 32'(g_dut[1].dut.pht_q[0]), 32'd2);

    // Repeated not-taken: counter floors at 0 and no BTB allocation.
    for (int i = 0; i < 3; i++) upd(32'h204, 1'b1, 1'b0, 32'h900, 1'b0);
    chk("bimodal_sat_lo", 1, 32'(g_dut[1].dut.pht_q[1]), 32'd0);
    look("nt_no_alloc", 32'h204, 3'b000, 32'h208, 32'h208, 32'h208, 1'b0, 32'd0);

    // Mispredict counter saturation.
    force g_dut[0].dut.mispredict_cnt_q = 32'hFFFF_FFFE;
    #1 release g_dut[0].dut.mispredict_cnt_q;
    for (int i = 0; i < 3; i++) begin
      upd(32'h300, 1'b0, 1'b0, 32'hA00, 1'b1);
      chk($sformatf("cnt_sat%0d", i), 0, cnt_s[0], 32'hFFFF_FFFF);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
